// File: rtl/operand_fetch.sv
// operand_fetch: operand-fetch stage feeding the 16-bit ALU.
//
// Holds the 8x16 general register file and accepts one decoded instruction at a
// time over a valid/ready handshake. Rn and Rm are read over successive cycles
// through a single read port. Rm passes through a 1-bit shifter, or an immediate
// replaces it. The operands and ALU op are then held for the ALU under a
// valid/ready handshake. The writeback stage drives the register file write port.
//
// Ports:
//   clk, rst             rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready    instruction handshake (in_ready high only in IDLE)
//   rn, rm               source register indices for val_A / val_B
//   shift                Rm shift: 00 none, 01 LSL1, 10 LSR1, 11 ASR1
//   use_imm, sximm5      select the sign-extended immediate as val_B
//   ALU_op_in            op forwarded to the ALU
//   wr_en/addr/data      register file write port (active in every state)
//   out_valid/out_ready  operand handshake towards the ALU
//   val_A, val_B, ALU_op operands and latched op
//
// Build option:
//   OPFETCH_BYPASS_EN    when defined, a read of the index being written on the
//                        same edge returns wr_data (write-first). When undefined,
//                        the read returns the old register value.

module operand_fetch (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  rn,
  input  logic [2:0]  rm,
  input  logic [1:0]  shift,
  input  logic        use_imm,
  input  logic [15:0] sximm5,
  input  logic [1:0]  ALU_op_in,
  input  logic        wr_en,
  input  logic [2:0]  wr_addr,
  input  logic [15:0] wr_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] val_A,
  output logic [15:0] val_B,
  output logic [1:0]  ALU_op
);

  typedef enum logic [1:0] {StIdle, StLoadA, StLoadB, StHold} state_e;

  state_e      state_q, state_d;
  logic [2:0]  rn_q, rn_d;
  logic [2:0]  rm_q, rm_d;
  logic [1:0]  shift_q, shift_d;
  logic        use_imm_q, use_imm_d;
  logic [1:0]  alu_op_q, alu_op_d;
  logic [15:0] val_a_q, val_a_d;
  logic [15:0] val_b_q, val_b_d;
  logic        out_valid_q, out_valid_d;
  logic [15:0] regs_q [8];

  logic [2:0]  rd_addr;
  logic [15:0] rd_data;
  logic [15:0] shifted;

  // Single read port: Rm only in LOAD_B, Rn otherwise.
  always_comb begin
    rd_addr = (state_q == StLoadB) ? rm_q : rn_q;
`ifdef OPFETCH_BYPASS_EN
    if (wr_en && (wr_addr == rd_addr)) begin
      rd_data = wr_data;
    end else begin
      rd_data = regs_q[rd_addr];
    end
`else
    rd_data = regs_q[rd_addr];
`endif
  end

  always_comb begin
    shifted = rd_data;
    case (shift_q)
      2'b01:   shifted = {rd_data[14:0], 1'b0};
      2'b10:   shifted = {1'b0, rd_data[15:1]};
      2'b11:   shifted = {rd_data[15], rd_data[15:1]};
      default: shifted = rd_data;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    rn_d      = rn_q;
    rm_d      = rm_q;
    shift_d   = shift_q;
    use_imm_d = use_imm_q;
    alu_op_d  = alu_op_q;
    val_a_d   = val_a_q;
    val_b_d   = val_b_q;
    case (state_q)
      StIdle: begin
        if (in_valid) begin
          rn_d      = rn;
          rm_d      = rm;
          shift_d   = shift;
          use_imm_d = use_imm;
          alu_op_d  = ALU_op_in;
          if (use_imm) begin
            val_b_d = sximm5;
          end
          state_d = StLoadA;
        end
      end
      StLoadA: begin
        val_a_d = rd_data;
        state_d = use_imm_q ? StHold : StLoadB;
      end
      StLoadB: begin
        val_b_d = shifted;
        state_d = StHold;
      end
      StHold: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    // Registered so out_valid is glitch-free and aligned with the latched operands.
    out_valid_d = (state_d == StHold);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      rn_q        <= 3'd0;
      rm_q        <= 3'd0;
      shift_q     <= 2'd0;
      use_imm_q   <= 1'b0;
      alu_op_q    <= 2'd0;
      val_a_q     <= 16'd0;
      val_b_q     <= 16'd0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rn_q        <= rn_d;
      rm_q        <= rm_d;
      shift_q     <= shift_d;
      use_imm_q   <= use_imm_d;
      alu_op_q    <= alu_op_d;
      val_a_q     <= val_a_d;
      val_b_q     <= val_b_d;
      out_valid_q <= out_valid_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) begin
        regs_q[i] <= 16'd0;
      end
    end else if (wr_en) begin
      regs_q[wr_addr] <= wr_data;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = out_valid_q;
  assign val_A     = val_a_q;
  assign val_B     = val_b_q;
  assign ALU_op    = alu_op_q;

endmodule

// File: tb/tb_operand_fetch.sv
// tb_operand_fetch: directed self-checking bench for operand_fetch.
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.

module tb_operand_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  rn = 3'd0;
  logic [2:0]  rm = 3'd0;
  logic [1:0]  shift = 2'd0;
  logic        use_imm = 1'b0;
  logic [15:0] sximm5 = 16'd0;
  logic [1:0]  ALU_op_in = 2'd0;
  logic        wr_en = 1'b0;
  logic [2:0]  wr_addr = 3'd0;
  logic [15:0] wr_data = 16'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] val_A;
  logic [15:0] val_B;
  logic [1:0]  ALU_op;

  int checks = 0;
  int failures = 0;

  operand_fetch dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .rn        (rn),
    .rm        (rm),
    .shift     (shift),
    .use_imm   (use_imm),
    .sximm5    (sximm5),
    .ALU_op_in (ALU_op_in),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .val_A     (val_A),
    .val_B     (val_B),
    .ALU_op    (ALU_op)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [2:0] a, input logic [15:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    step();
    wr_en = 1'b0;
  endtask

  // Called in IDLE; returns just after the accept edge (stage in LOAD_A).
  task automatic issue(input logic [2:0] a, input logic [2:0] b, input logic [1:0] sh,
                       input logic imm, input logic [15:0] im, input logic [1:0] op);
    in_valid = 1'b1; rn = a; rm = b; shift = sh; use_imm = imm; sximm5 = im; ALU_op_in = op;
    step();
    in_valid = 1'b0;
  endtask

  task automatic consume();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #2 rst = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rst_in_ready got=%h exp=1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid got=%h exp=0", out_valid); end
    checks++; if (val_A !== 16'h0000) begin failures++; $display("FAIL rst_val_A got=%h exp=0000", val_A); end
    checks++; if (val_B !== 16'h0000) begin failures++; $display("FAIL rst_val_B got=%h exp=0000", val_B); end
    checks++; if (ALU_op !== 2'd0) begin failures++; $display("FAIL rst_ALU_op got=%h exp=0", ALU_op); end
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_basic();
    do_write(3'd1, 16'h0005);
    do_write(3'd2, 16'h0003);
    issue(3'd1, 3'd2, 2'b00, 1'b0, 16'h0000, 2'b01);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL basic_ov_t0 got=%h exp=0", out_valid); end
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL basic_ir_t0 got=%h exp=0", in_ready); end
    step();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL basic_ov_t1 got=%h exp=0", out_valid); end
    checks++; if (val_A !== 16'h0005) begin failures++; $display("FAIL basic_val_A got=%h exp=0005", val_A); end
    step();
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL basic_ov_t2 got=%h exp=1", out_valid); end
    checks++; if (val_B !== 16'h0003) begin failures++; $display("FAIL basic_val_B got=%h exp=0003", val_B); end
    checks++; if (ALU_op !== 2'b01) begin failures++; $display("FAIL basic_ALU_op got=%h exp=1", ALU_op); end
    consume();
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL basic_idle got=%h exp=1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL basic_ov_done got=%h exp=0", out_valid); end
  endtask

  task automatic test_shift();
    logic [15:0] exp_b [4];
    exp_b[0] = 16'h8001; exp_b[1] = 16'h0002; exp_b[2] = 16'h4000; exp_b[3] = 16'hC000;
    do_write(3'd3, 16'h8001);
    for (int i = 0; i < 4; i++) begin
      issue(3'd0, 3'd3, 2'(i), 1'b0, 16'h0000, 2'b10);
      step();
      step();
      checks++; if (val_B !== exp_b[i]) begin failures++; $display("FAIL shift_%0d got=%h exp=%h", i, val_B, exp_b[i]); end
      checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL shift_ov_%0d got=%h exp=1", i, out_valid); end
      consume();
    end
  endtask

  task automatic test_imm();
    do_write(3'd4, 16'h7FFF);
    issue(3'd4, 3'd3, 2'b01, 1'b1, 16'hFFF0, 2'b11);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL imm_ov_t0 got=%h exp=0", out_valid); end
    step();
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL imm_ov_t1 got=%h exp=1", out_valid); end
    checks++; if (val_A !== 16'h7FFF) begin failures++; $display("FAIL imm_val_A got=%h exp=7fff", val_A); end
    checks++; if (val_B !== 16'hFFF0) begin failures++; $display("FAIL imm_val_B got=%h exp=fff0", val_B); end
    checks++; if (ALU_op !== 2'b11) begin failures++; $display("FAIL imm_ALU_op got=%h exp=3", ALU_op); end
    consume();
  endtask

  task automatic test_bypass();
    logic [15:0] exp_b;
`ifdef OPFETCH_BYPASS_EN
    exp_b = 16'h1234;
`else
    exp_b = 16'h0000;
`endif
    issue(3'd1, 3'd5, 2'b00, 1'b0, 16'h0000, 2'b00);
    step();
    // Now in LOAD_B: write rm on the same edge it is read.
    wr_en = 1'b1; wr_addr = 3'd5; wr_data = 16'h1234;
    step();
    wr_en = 1'b0;
    checks++; if (val_B !== exp_b) begin failures++; $display("FAIL bypass_val_B got=%h exp=%h", val_B, exp_b); end
    consume();
    issue(3'd5, 3'd5, 2'b00, 1'b0, 16'h0000, 2'b00);
    step();
    step();
    checks++; if (val_A !== 16'h1234) begin failures++; $display("FAIL bypass_later_A got=%h exp=1234", val_A); end
    checks++; if (val_B !== 16'h1234) begin failures++; $display("FAIL bypass_later_B got=%h exp=1234", val_B); end
    consume();
  endtask

  task automatic test_hold();
    issue(3'd1, 3'd2, 2'b00, 1'b0, 16'h0000, 2'b01);
    step();
    step();
    for (int i = 0; i < 5; i++) begin
      wr_en = 1'b1; wr_addr = 3'd1; wr_data = 16'hAAAA + 16'(i);
      step();
      checks++; if (val_A !== 16'h0005) begin failures++; $display("FAIL hold_val_A_%0d got=%h exp=0005", i, val_A); end
      checks++; if (val_B !== 16'h0003) begin failures++; $display("FAIL hold_val_B_%0d got=%h exp=0003", i, val_B); end
      checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL hold_ov_%0d got=%h exp=1", i, out_valid); end
      checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL hold_ir_%0d got=%h exp=0", i, in_ready); end
    end
    wr_en = 1'b0;
    consume();
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL hold_release got=%h exp=1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL hold_ov_release got=%h exp=0", out_valid); end
  endtask

  task automatic test_back_to_back();
    // out_ready held high throughout; it must be ignored until out_valid rises.
    out_ready = 1'b1;
    in_valid = 1'b1; rn = 3'd4; rm = 3'd0; shift = 2'b00; use_imm = 1'b1;
    sximm5 = 16'h0011; ALU_op_in = 2'b01;
    step();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL b2b_ov_t0 got=%h exp=0", out_valid); end
    step();
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL b2b_ov_t1 got=%h exp=1", out_valid); end
    checks++; if (val_B !== 16'h0011) begin failures++; $display("FAIL b2b_val_B1 got=%h exp=0011", val_B); end
    step();
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL b2b_idle got=%h exp=1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL b2b_ov_idle got=%h exp=0", out_valid); end
    in_valid = 1'b1; sximm5 = 16'h0022; ALU_op_in = 2'b10;
    step();
    in_valid = 1'b0;
    step();
    checks++; if (val_B !== 16'h0022) begin failures++; $display("FAIL b2b_val_B2 got=%h exp=0022", val_B); end
    checks++; if (ALU_op !== 2'b10) begin failures++; $display("FAIL b2b_ALU_op2 got=%h exp=2", ALU_op); end
    step();
    out_ready = 1'b0;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL b2b_idle2 got=%h exp=1", in_ready); end
  endtask

  task automatic test_rst_mid();
    issue(3'd1, 3'd2, 2'b00, 1'b0, 16'h0000, 2'b01);
    #1 rst = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rstmid_ov got=%h exp=0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rstmid_ir got=%h exp=1", in_ready); end
    #1 rst = 1'b0;
    step();
    for (int i = 0; i < 8; i++) begin
      issue(3'(i), 3'(i), 2'b00, 1'b0, 16'h0000, 2'b00);
      step();
      step();
      checks++;
      if (val_A !== 16'h0000 || val_B !== 16'h0000 || out_valid !== 1'b1) begin
        failures++;
        $display("FAIL rstmid_r%0d got=%h/%h ov=%h exp=0000/0000 ov=1", i, val_A, val_B, out_valid);
      end
      consume();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_shift();
    test_imm();
    test_bypass();
    test_hold();
    test_back_to_back();
    test_rst_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/operand_fetch.md
# operand_fetch

Operand-fetch stage directly upstream of the 16-bit ALU. It holds the 8×16 general register file, accepts one decoded instruction at a time through a valid/ready handshake, and reads Rn into val_A and Rm into val_B over successive cycles through a single read port. Rm passes through a 1-bit shifter; a sign-extended immediate can replace it. The stage presents val_A, val_B and ALU_op to the ALU with a valid/ready handshake. The register file's write port is driven by the downstream writeback stage.

## Interface
- No parameters; all widths are fixed (16-bit data, 8 registers).
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  decoded instruction present
- in_ready  out  1  stage can accept; high only in IDLE
- rn  in  3  register index for val_A
- rm  in  3  register index for val_B
- shift  in  2  shift applied to Rm: 00 none, 01 LSL1, 10 LSR1 (zero fill), 11 ASR1
- use_imm  in  1  1: val_B = sximm5, Rm not read
- sximm5  in  16  sign-extended immediate
- ALU_op_in  in  2  operation forwarded to the ALU
- wr_en  in  1  register file write enable
- wr_addr  in  3  write index
- wr_data  in  16  write data
- out_valid  out  1  operands valid
- out_ready  in  1  ALU stage consumes operands
- val_A  out  16  Rn operand
- val_B  out  16  shifted Rm operand or sximm5
- ALU_op  out  2  latched ALU_op_in

## Operation
- States: IDLE, LOAD_A, LOAD_B, HOLD.
- IDLE: in_ready=1. On in_valid&in_ready, latch rn, rm, shift, use_imm, ALU_op_in, then go to LOAD_A. If use_imm, also latch val_B=sximm5.
- LOAD_A: read reg[rn] and latch it into val_A. Next state is HOLD if use_imm, otherwise LOAD_B.
- LOAD_B: read reg[rm], apply the shift, latch the result into val_B, then go to HOLD.
- HOLD: out_valid=1. val_A, val_B and ALU_op stay stable until out_valid&out_ready, then go to IDLE.
- Shifter, all modes 16-bit:
  - LSL1: {b[14:0],0}
  - LSR1: {0,b[15:1]}
  - ASR1: {b[15],b[15:1]}
  - 0x8001 ASR1 gives 0xC000.
- Writes: reg[wr_addr]<=wr_data on any edge where wr_en=1, in every state.
- Same-cycle write and read of the same index: see Configuration.
- A write to a register that is already latched does not alter val_A or val_B.
- rn==rm is legal; both reads return the same register, subject to intervening writes.

## Timing
- Reset values:
  - state=IDLE, in_ready=1, out_valid=0.
  - val_A=0, val_B=0, ALU_op=0, all 8 registers=0.
- Accept edge T:
  - Register source: val_A valid after T+1, val_B after T+2, out_valid=1 from T+2 (latency 2 cycles after accept).
  - Immediate source: out_valid=1 from T+1.
- Back-to-back instructions: after the consuming edge, state is IDLE for one cycle. Throughput is 1 instruction per 4 cycles (register source) or 3 cycles (immediate).
- in_ready is combinational from state only; out_valid is registered.
- out_ready while out_valid=0 is ignored.
- rst mid-operation aborts immediately: the register file is cleared, the in-flight instruction is dropped, and out_valid falls asynchronously.

## Configuration
- OPFETCH_BYPASS_EN defined: write-first forwarding. A read of an index written on the same edge returns wr_data.
- Not defined: read-before-write. The read returns the old register value; the new value is visible from the next cycle.

## Test plan
- Reset then write r1=0x0005 and r2=0x0003. Issue rn=1, rm=2, shift=00, ALU_op_in=01. Expected: out_valid at T+2 with val_A=0x0005, val_B=0x0003, ALU_op=01.
- rm=r3=0x8001 with each shift code. Expected val_B: 0x8001, 0x0002, 0x4000, 0xC000.
- use_imm=1, sximm5=0xFFF0, rn=r4=0x7FFF. Expected: out_valid at T+1 with val_A=0x7FFF, val_B=0xFFF0.
- In LOAD_B, wr_en with wr_addr=rm, wr_data=0x1234, old value 0x0000. Expected val_B: 0x1234 with the macro, 0x0000 without.
- Hold out_ready=0 for 5 cycles in HOLD while writing rn. Expected: outputs stable, in_ready=0; IDLE one cycle after out_ready=1.
- Assert rst during LOAD_A. Expected: out_valid=0, in_ready=1 immediately; every register reads back 0x0000 afterwards.
